carbon_dbg_runctl: RTL and testbench
====================================

# carbon_dbg_runctl

Debug run-control responder for a Carbon core. It serves the target side of the debug protocol: `dbg_if`-style halt/run/step request pulses, and the privileged CSR mirror (`DBG_CTRL`, `DBG_STEP`, `DBG_STATUS`). It gates the core's execution enable and reports halt and step completion back to both request paths. It sits between the core pipeline and the `dbg_if` and `csr_if` ports of the core top level.

## Interface
- `CSR_DBG_CTRL_ADDR`, default `CARBON_CSR_DBG_CTRL`: CSR address of the control register.
- `CSR_DBG_STEP_ADDR`, default `CARBON_CSR_DBG_STEP`: CSR address of the step register.
- `CSR_DBG_STATUS_ADDR`, default `CARBON_CSR_DBG_STATUS`: CSR address of the status register.
- `MIN_PRIV`, default `2'd1`: lowest privilege level allowed to access the debug CSRs.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `halt_req`, `run_req`, `step_req` in 1 each: `dbg_if` request pulses.
- `halt_ack` out 1: level, high while the block is HALTED.
- `step_ack` out 1: one-cycle pulse when a step completes.
- `csr_req_valid` in 1, `csr_req_ready` out 1: CSR request handshake.
- `csr_req_write` in 1: 1 selects a write.
- `csr_req_addr` in 32: CSR address.
- `csr_req_wdata` in 32: write data.
- `csr_req_wstrb` in 4: byte enables.
- `csr_req_priv` in 2: privilege of the requester.
- `csr_rsp_valid` out 1, `csr_rsp_rdata` out 32, `csr_rsp_fault` out 1: CSR response.
- `core_run_en` out 1: core may issue instructions.
- `core_retire` in 1: pulse, one instruction retired.
- `core_idle` in 1: core is at an instruction boundary with no instruction in flight.

## Operation
- FSM states: RUN, HALT_PEND, HALTED, STEP_EXEC, STEP_DRAIN.
- **RUN**: `core_run_en=1`. A halt source moves the FSM to HALT_PEND. Halt sources are a `halt_req` pulse or a CTRL write with bit0=1.
- **HALT_PEND**: `core_run_en=0`. When `core_idle=1`, go to HALTED.
- **HALTED**: `halt_ack=1`, `core_run_en=0`.
  - Step source → STEP_EXEC, and clear `step_done`. Step sources are a `step_req` pulse or a STEP write with bit0=1.
  - Run source → RUN, and clear `step_done`. Run sources are a `run_req` pulse or a CTRL write with bit0=0.
- **STEP_EXEC**: `core_run_en=1`. On `core_retire`, `core_run_en` drops in that same cycle (combinational) and the FSM goes to STEP_DRAIN.
- **STEP_DRAIN**: `core_run_en=0`. When `core_idle=1`: go to HALTED, pulse `step_ack` for one cycle, set sticky `step_done`.
- Simultaneous sources: halt > step > run.
  - A halt during STEP_EXEC forces STEP_DRAIN with no `step_ack`; the FSM still ends in HALTED.
- Ignored requests:
  - step or run in RUN, HALT_PEND, STEP_EXEC or STEP_DRAIN;
  - halt in HALT_PEND, HALTED or STEP_DRAIN.
- `DBG_STATUS` read value:
  - bit0 = HALTED
  - bit1 = `step_done`
  - bit2 = HALT_PEND or STEP_DRAIN (busy)
  - bits 31:3 = 0
- `DBG_CTRL` read value: bit0 = a halt is in effect (any state other than RUN). `DBG_STEP` reads as 0.
- CSR writes take effect only when `wstrb[0]=1`. Otherwise the write is a no-op with no fault.
- A CSR access faults (`fault=1`, `rdata=0`, no side effect) when:
  - `csr_req_priv < MIN_PRIV`, or
  - the address matches none of the three registers, or
  - the access is a write to `DBG_STATUS`.

## Timing
- Reset values: state RUN, `core_run_en=1`, `halt_ack=0`, `step_ack=0`, `step_done=0`, `csr_req_ready=1`, `csr_rsp_valid=0`, `csr_rsp_rdata=0`, `csr_rsp_fault=0`.
- A request pulse sampled at edge N is seen as a state change at edge N.
  - `core_run_en` is low from the cycle after N.
  - With `core_idle` already high, `halt_ack` is high 2 cycles after the pulse.
- `run_req` in HALTED: `halt_ack` falls and `core_run_en` rises on the next cycle.
- CSR handshake:
  - The request is accepted on `valid & ready`.
  - The response is registered: `csr_rsp_valid` pulses exactly 1 cycle after acceptance.
  - `csr_req_ready=0` during the response cycle, which gives one outstanding request at most.
  - A CSR-sourced command acts in the same cycle as acceptance.
- A CSR source and a `dbg_if` source in the same cycle are merged under the priority rule above.
- A `DBG_STATUS` read returns the state as of the acceptance cycle.
- Reset mid-step or mid-transaction: everything returns to reset values next cycle; any pending response is dropped.

## Structure
- The shared `carbon_arch_pkg` holds:
  - the state enum `carbon_dbg_state_e`;
  - the `DBG_STATUS` bit-position constants (HALTED=0, STEP_DONE=1, BUSY=2);
  - the `DBG_CTRL` halt-bit constant.
- Natural sub-module: `carbon_dbg_csr_regs`, which handles CSR decode, privilege check and the registered response, and emits halt/run/step command pulses to the FSM.

## Test plan
- Halt with `core_idle` held at 0 for 5 cycles: FSM stays in HALT_PEND, `halt_ack=0`, `core_run_en=0`. Then raise `core_idle`: `halt_ack=1` on the next cycle.
- Step from HALTED with `core_retire` pulsed 3 cycles later:
  - `core_run_en=1` for exactly 3 cycles;
  - `step_ack` pulses once;
  - returns to HALTED;
  - `DBG_STATUS` reads `0x3`.
- CSR write `DBG_CTRL=0x1` at priv 1 → halt. Write `DBG_STEP=0x1` → status bit1 set after retire and idle. Write `DBG_CTRL=0x0` → `halt_ack=0`, and status then reads `0x0`.
- Privilege and decode faults, each with no state change:
  - `DBG_CTRL` write at priv 0 → `fault=1`;
  - read of an unknown address → `fault=1`, `rdata=0`;
  - write to `DBG_STATUS` → `fault=1`.
- `halt_req` and `run_req` in the same cycle while in RUN → halt wins. `step_req` while in RUN → ignored, `step_ack` never pulses.
- Reset asserted during STEP_EXEC with a CSR response pending → next cycle: RUN, `core_run_en=1`, `csr_rsp_valid=0`, `step_done=0`.

Source files
------------

// File: rtl/carbon_arch_pkg.sv
// Shared Carbon architecture definitions used by the debug run-control block:
// run-control state encoding, debug CSR addresses and register bit positions.
package carbon_arch_pkg;

    // Debug CSR addresses in the machine-debug CSR window.
    localparam logic [31:0] CARBON_CSR_DBG_CTRL   = 32'h0000_07C0;
    localparam logic [31:0] CARBON_CSR_DBG_STEP   = 32'h0000_07C1;
    localparam logic [31:0] CARBON_CSR_DBG_STATUS = 32'h0000_07C2;

    // DBG_STATUS bit positions.
    localparam int DBG_STATUS_HALTED_BIT    = 0;
    localparam int DBG_STATUS_STEP_DONE_BIT = 1;
    localparam int DBG_STATUS_BUSY_BIT      = 2;

    // DBG_CTRL: 1 requests a halt, 0 requests a resume.
    localparam int DBG_CTRL_HALT_BIT = 0;

    // DBG_STEP: 1 requests a single step.
    localparam int DBG_STEP_GO_BIT = 0;

    // Run-control state.
    typedef enum logic [2:0] {
        DBG_ST_RUN        = 3'd0,
        DBG_ST_HALT_PEND  = 3'd1,
        DBG_ST_HALTED     = 3'd2,
        DBG_ST_STEP_EXEC  = 3'd3,
        DBG_ST_STEP_DRAIN = 3'd4
    } carbon_dbg_state_e;

    // Compose the DBG_STATUS read value from the run-control state.
    function automatic logic [31:0] dbg_status_word(input carbon_dbg_state_e st,
                                                    input logic step_done);
        logic [31:0] w;
        w = '0;
        w[DBG_STATUS_HALTED_BIT]    = (st == DBG_ST_HALTED);
        w[DBG_STATUS_STEP_DONE_BIT] = step_done;
        w[DBG_STATUS_BUSY_BIT]      = (st == DBG_ST_HALT_PEND) ||
                                      (st == DBG_ST_STEP_DRAIN);
        return w;
    endfunction

    // Compose the DBG_CTRL read value: halt bit set whenever not running.
    function automatic logic [31:0] dbg_ctrl_word(input carbon_dbg_state_e st);
        logic [31:0] w;
        w = '0;
        w[DBG_CTRL_HALT_BIT] = (st != DBG_ST_RUN);
        return w;
    endfunction

endpackage

// File: rtl/carbon_dbg_runctl_if.sv
// Privileged CSR request/response bus between the core CSR unit (master)
// and the debug run-control responder (slave).
interface carbon_dbg_runctl_if;

    logic        csr_req_valid;
    logic        csr_req_ready;
    logic        csr_req_write;
    logic [31:0] csr_req_addr;
    logic [31:0] csr_req_wdata;
    logic [3:0]  csr_req_wstrb;
    logic [1:0]  csr_req_priv;
    logic        csr_rsp_valid;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_fault;

    modport master (
        output csr_req_valid,
        input  csr_req_ready,
        output csr_req_write,
        output csr_req_addr,
        output csr_req_wdata,
        output csr_req_wstrb,
        output csr_req_priv,
        input  csr_rsp_valid,
        input  csr_rsp_rdata,
        input  csr_rsp_fault
    );

    modport slave (
        input  csr_req_valid,
        output csr_req_ready,
        input  csr_req_write,
        input  csr_req_addr,
        input  csr_req_wdata,
        input  csr_req_wstrb,
        input  csr_req_priv,
        output csr_rsp_valid,
        output csr_rsp_rdata,
        output csr_rsp_fault
    );

endinterface

// File: rtl/carbon_dbg_csr_regs.sv
// Debug CSR front end: address decode, privilege check, registered response
// and translation of accepted writes into halt/run/step command pulses.
module carbon_dbg_csr_regs
    import carbon_arch_pkg::*;
#(
    parameter logic [31:0] CSR_DBG_CTRL_ADDR   = CARBON_CSR_DBG_CTRL,
    parameter logic [31:0] CSR_DBG_STEP_ADDR   = CARBON_CSR_DBG_STEP,
    parameter logic [31:0] CSR_DBG_STATUS_ADDR = CARBON_CSR_DBG_STATUS,
    parameter logic [1:0]  MIN_PRIV            = 2'd1
) (
    input  logic              clk,
    input  logic              rst,
    carbon_dbg_runctl_if.slave csr,
    input  carbon_dbg_state_e state_i,
    input  logic              step_done_i,
    output logic              cmd_halt_o,
    output logic              cmd_run_o,
    output logic              cmd_step_o
);

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_fault_q, rsp_fault_d;

    logic accept;
    logic hit_ctrl, hit_step, hit_status;
    logic access_fault;
    logic unused_wbits;

    // Only one request in flight: ready drops during the response cycle.
    assign accept = csr.csr_req_valid & ~rsp_valid_q;

    assign hit_ctrl   = (csr.csr_req_addr == CSR_DBG_CTRL_ADDR);
    assign hit_step   = (csr.csr_req_addr == CSR_DBG_STEP_ADDR);
    assign hit_status = (csr.csr_req_addr == CSR_DBG_STATUS_ADDR);

    // Faulting accesses return zero data and have no side effect.
    assign access_fault = (csr.csr_req_priv < MIN_PRIV) ||
                          !(hit_ctrl || hit_step || hit_status) ||
                          (csr.csr_req_write && hit_status);

    // Only bit 0 of the lowest byte carries meaning in any debug register.
    assign unused_wbits = ^{csr.csr_req_wdata[31:1], csr.csr_req_wstrb[3:1]};

    // Decode the accepted request into command pulses and the next response.
    always_comb begin
        cmd_halt_o  = 1'b0;
        cmd_run_o   = 1'b0;
        cmd_step_o  = 1'b0;
        rsp_valid_d = accept;
        rsp_rdata_d = '0;
        rsp_fault_d = 1'b0;
        if (accept) begin
            if (access_fault) begin
                rsp_fault_d = 1'b1;
            end else if (csr.csr_req_write) begin
                if (csr.csr_req_wstrb[0]) begin
                    if (hit_ctrl) begin
                        if (csr.csr_req_wdata[DBG_CTRL_HALT_BIT]) begin
                            cmd_halt_o = 1'b1;
                        end else begin
                            cmd_run_o = 1'b1;
                        end
                    end else if (hit_step && csr.csr_req_wdata[DBG_STEP_GO_BIT]) begin
                        cmd_step_o = 1'b1;
                    end
                end
            end else begin
                if (hit_ctrl) begin
                    rsp_rdata_d = dbg_ctrl_word(state_i);
                end else if (hit_status) begin
                    rsp_rdata_d = dbg_status_word(state_i, step_done_i);
                end
            end
        end
    end

    // Response register; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign csr.csr_req_ready = ~rsp_valid_q;
    assign csr.csr_rsp_valid = rsp_valid_q;
    assign csr.csr_rsp_rdata = rsp_rdata_q;
    assign csr.csr_rsp_fault = rsp_fault_q;

endmodule

// File: rtl/carbon_dbg_runctl.sv
// Debug run-control responder: merges dbg_if request pulses with CSR-sourced
// commands, gates core execution and reports halt/step completion.
module carbon_dbg_runctl
    import carbon_arch_pkg::*;
#(
    parameter logic [31:0] CSR_DBG_CTRL_ADDR   = CARBON_CSR_DBG_CTRL,
    parameter logic [31:0] CSR_DBG_STEP_ADDR   = CARBON_CSR_DBG_STEP,
    parameter logic [31:0] CSR_DBG_STATUS_ADDR = CARBON_CSR_DBG_STATUS,
    parameter logic [1:0]  MIN_PRIV            = 2'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt_req,
    input  logic               run_req,
    input  logic               step_req,
    output logic               halt_ack,
    output logic               step_ack,
    carbon_dbg_runctl_if.slave csr,
    output logic               core_run_en,
    input  logic               core_retire,
    input  logic               core_idle
);

    carbon_dbg_state_e state_q, state_d;
    logic step_done_q, step_done_d;
    logic step_ack_q, step_ack_d;
    logic step_abort_q, step_abort_d;

    logic cmd_halt, cmd_run, cmd_step;
    logic halt_src, run_src, step_src;

    carbon_dbg_csr_regs #(
        .CSR_DBG_CTRL_ADDR  (CSR_DBG_CTRL_ADDR),
        .CSR_DBG_STEP_ADDR  (CSR_DBG_STEP_ADDR),
        .CSR_DBG_STATUS_ADDR(CSR_DBG_STATUS_ADDR),
        .MIN_PRIV           (MIN_PRIV)
    ) u_csr_regs (
        .clk        (clk),
        .rst        (rst),
        .csr        (csr),
        .state_i    (state_q),
        .step_done_i(step_done_q),
        .cmd_halt_o (cmd_halt),
        .cmd_run_o  (cmd_run),
        .cmd_step_o (cmd_step)
    );

    // Both request paths feed the same sources; priority is resolved below.
    assign halt_src = halt_req | cmd_halt;
    assign run_src  = run_req  | cmd_run;
    assign step_src = step_req | cmd_step;

    // Next-state and execution gating; halt beats step beats run.
    always_comb begin
        state_d      = state_q;
        step_done_d  = step_done_q;
        step_ack_d   = 1'b0;
        step_abort_d = step_abort_q;
        core_run_en  = 1'b0;
        case (state_q)
            DBG_ST_RUN: begin
                core_run_en = 1'b1;
                if (halt_src) begin
                    state_d = DBG_ST_HALT_PEND;
                end
            end
            DBG_ST_HALT_PEND: begin
                if (core_idle) begin
                    state_d = DBG_ST_HALTED;
                end
            end
            DBG_ST_HALTED: begin
                if (!halt_src) begin
                    if (step_src) begin
                        state_d      = DBG_ST_STEP_EXEC;
                        step_done_d  = 1'b0;
                        step_abort_d = 1'b0;
                    end else if (run_src) begin
                        state_d     = DBG_ST_RUN;
                        step_done_d = 1'b0;
                    end
                end
            end
            DBG_ST_STEP_EXEC: begin
                // Drop enable in the retire cycle so only one instruction issues.
                core_run_en = ~core_retire;
                if (halt_src) begin
                    state_d      = DBG_ST_STEP_DRAIN;
                    step_abort_d = 1'b1;
                end else if (core_retire) begin
                    state_d      = DBG_ST_STEP_DRAIN;
                    step_abort_d = 1'b0;
                end
            end
            DBG_ST_STEP_DRAIN: begin
                if (core_idle) begin
                    state_d = DBG_ST_HALTED;
                    if (!step_abort_q) begin
                        step_ack_d  = 1'b1;
                        step_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = DBG_ST_RUN;
            end
        endcase
    end

    // Run-control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= DBG_ST_RUN;
            step_done_q  <= 1'b0;
            step_ack_q   <= 1'b0;
            step_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_done_q  <= step_done_d;
            step_ack_q   <= step_ack_d;
            step_abort_q <= step_abort_d;
        end
    end

    assign halt_ack = (state_q == DBG_ST_HALTED);
    assign step_ack = step_ack_q;

endmodule

// File: tb/tb_carbon_dbg_runctl.sv
// Directed bench for the debug run-control responder.
module tb_carbon_dbg_runctl;

    localparam logic [31:0] A_CTRL   = 32'h0000_07C0;
    localparam logic [31:0] A_STEP   = 32'h0000_07C1;
    localparam logic [31:0] A_STATUS = 32'h0000_07C2;
    localparam logic [31:0] A_BAD    = 32'h0000_0123;

    logic clk = 1'b0;
    logic rst;
    logic halt_req, run_req, step_req;
    logic halt_ack, step_ack;
    logic core_run_en, core_retire, core_idle;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rd;
    logic        flt;

    carbon_dbg_runctl_if csr_bus ();

    carbon_dbg_runctl dut (
        .clk        (clk),
        .rst        (rst),
        .halt_req   (halt_req),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_ack   (halt_ack),
        .step_ack   (step_ack),
        .csr        (csr_bus),
        .core_run_en(core_run_en),
        .core_retire(core_retire),
        .core_idle  (core_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One CSR transaction: drive, accept at the next edge, sample the response.
    task automatic csr_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [1:0] priv,
                            output logic [31:0] rdata, output logic fault);
        chk("csr_ready", {31'd0, csr_bus.csr_req_ready}, 32'd1);
        csr_bus.csr_req_valid = 1'b1;
        csr_bus.csr_req_write = wr;
        csr_bus.csr_req_addr  = addr;
        csr_bus.csr_req_wdata = wdata;
        csr_bus.csr_req_wstrb = strb;
        csr_bus.csr_req_priv  = priv;
        cyc();
        csr_bus.csr_req_valid = 1'b0;
        chk("csr_rsp_valid", {31'd0, csr_bus.csr_rsp_valid}, 32'd1);
        chk("csr_ready_busy", {31'd0, csr_bus.csr_req_ready}, 32'd0);
        rdata = csr_bus.csr_rsp_rdata;
        fault = csr_bus.csr_rsp_fault;
        $display("csr %s addr=0x%08h wdata=0x%08h strb=%b priv=%0d -> rdata=0x%08h fault=%b",
                 wr ? "wr" : "rd", addr, wdata, strb, priv, rdata, fault);
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
        core_retire = 1'b0; core_idle = 1'b0;
        csr_bus.csr_req_valid = 1'b0;
        csr_bus.csr_req_write = 1'b0;
        csr_bus.csr_req_addr  = '0;
        csr_bus.csr_req_wdata = '0;
        csr_bus.csr_req_wstrb = '0;
        csr_bus.csr_req_priv  = '0;
        cyc();
        cyc();

        // Reset values.
        chk("rst_run_en",    {31'd0, core_run_en}, 32'd1);
        chk("rst_halt_ack",  {31'd0, halt_ack}, 32'd0);
        chk("rst_step_ack",  {31'd0, step_ack}, 32'd0);
        chk("rst_ready",     {31'd0, csr_bus.csr_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, csr_bus.csr_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", csr_bus.csr_rsp_rdata, 32'd0);
        chk("rst_rsp_fault", {31'd0, csr_bus.csr_rsp_fault}, 32'd0);
        rst = 1'b0;
        cyc();
        csr_xfer(1'b0, A_STATUS, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("rst_status", rd, 32'h0);

        // Halt with the core busy: stays pending.
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        $display("halt_req pulse, core_idle=0");
        chk("hp_run_en", {31'd0, core_run_en}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("hp_halt_ack", {31'd0, halt_ack}, 32'd0);
            chk("hp_run_en_hold", {31'd0, core_run_en}, 32'd0);
            cyc();
        end
        csr_xfer(1'b0, A_STATUS, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("hp_status_busy", rd, 32'h4);
        core_idle = 1'b1;
        cyc();
        chk("hp_halt_ack_idle", {31'd0, halt_ack}, 32'd1);

        // Single step via step_req; retire in the 4th execute cycle.
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        $display("step_req pulse from HALTED");
        chk("st_halt_ack", {31'd0, halt_ack}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("st_run_en", {31'd0, core_run_en}, 32'd1);
            chk("st_no_ack", {31'd0, step_ack}, 32'd0);
            cyc();
        end
        core_retire = 1'b1;
        core_idle   = 1'b0;
        #1;
        chk("st_retire_drop", {31'd0, core_run_en}, 32'd0);
        cyc();
        core_retire = 1'b0;
        chk("st_drain_run_en", {31'd0, core_run_en}, 32'd0);
        chk("st_drain_ack", {31'd0, step_ack}, 32'd0);
        core_idle = 1'b1;
        cyc();
        chk("st_ack_pulse", {31'd0, step_ack}, 32'd1);
        chk("st_halted", {31'd0, halt_ack}, 32'd1);
        cyc();
        chk("st_ack_one", {31'd0, step_ack}, 32'd0);
        csr_xfer(1'b0, A_STATUS, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("st_status", rd, 32'h3);
        csr_xfer(1'b0, A_CTRL, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("st_ctrl_rd", rd, 32'h1);
        csr_xfer(1'b0, A_STEP, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("st_step_rd", rd, 32'h0);

        // Resume via run_req.
        run_req = 1'b1;
        cyc();
        run_req = 1'b0;
        $display("run_req pulse from HALTED");
        chk("run_halt_ack", {31'd0, halt_ack}, 32'd0);
        chk("run_run_en", {31'd0, core_run_en}, 32'd1);
        csr_xfer(1'b0, A_STATUS, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("run_status", rd, 32'h0);

        // CSR-driven halt, step and resume.
        csr_bus.csr_req_valid = 1'b1;
        csr_bus.csr_req_write = 1'b1;
        csr_bus.csr_req_addr  = A_CTRL;
        csr_bus.csr_req_wdata = 32'h1;
        csr_bus.csr_req_wstrb = 4'h1;
        csr_bus.csr_req_priv  = 2'd1;
        cyc();
        csr_bus.csr_req_valid = 1'b0;
        $display("csr wr CTRL=1 priv=1");
        chk("ch_fault", {31'd0, csr_bus.csr_rsp_fault}, 32'd0);
        chk("ch_run_en", {31'd0, core_run_en}, 32'd0);
        chk("ch_pend_ack", {31'd0, halt_ack}, 32'd0);
        cyc();
        chk("ch_halt_ack", {31'd0, halt_ack}, 32'd1);
        csr_xfer(1'b1, A_STEP, 32'h1, 4'h1, 2'd1, rd, flt);
        chk("cs_fault", {31'd0, flt}, 32'd0);
        chk("cs_run_en", {31'd0, core_run_en}, 32'd1);
        core_retire = 1'b1;
        core_idle   = 1'b0;
        cyc();
        core_retire = 1'b0;
        core_idle   = 1'b1;
        cyc();
        chk("cs_step_ack", {31'd0, step_ack}, 32'd1);
        csr_xfer(1'b0, A_STATUS, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("cs_status", rd, 32'h3);
        csr_xfer(1'b1, A_CTRL, 32'h0, 4'h1, 2'd1, rd, flt);
        chk("cr_halt_ack", {31'd0, halt_ack}, 32'd0);
        chk("cr_run_en", {31'd0, core_run_en}, 32'd1);
        csr_xfer(1'b0, A_STATUS, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("cr_status", rd, 32'h0);

        // Faulting and no-op accesses leave the block running.
        csr_xfer(1'b1, A_CTRL, 32'h1, 4'h1, 2'd0, rd, flt);
        chk("f_priv_fault", {31'd0, flt}, 32'd1);
        chk("f_priv_run_en", {31'd0, core_run_en}, 32'd1);
        csr_xfer(1'b0, A_BAD, 32'd0, 4'h0, 2'd3, rd, flt);
        chk("f_addr_fault", {31'd0, flt}, 32'd1);
        chk("f_addr_rdata", rd, 32'h0);
        csr_xfer(1'b1, A_STATUS, 32'h1, 4'h1, 2'd1, rd, flt);
        chk("f_wr_status_fault", {31'd0, flt}, 32'd1);
        csr_xfer(1'b1, A_CTRL, 32'h1, 4'h2, 2'd1, rd, flt);
        chk("f_nostrb_fault", {31'd0, flt}, 32'd0);
        chk("f_nostrb_run_en", {31'd0, core_run_en}, 32'd1);
        csr_xfer(1'b0, A_STATUS, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("f_status", rd, 32'h0);

        // Halt and run together in RUN: halt wins.
        halt_req = 1'b1;
        run_req  = 1'b1;
        cyc();
        halt_req = 1'b0;
        run_req  = 1'b0;
        $display("halt_req+run_req in RUN");
        chk("pr_run_en", {31'd0, core_run_en}, 32'd0);
        cyc();
        chk("pr_halt_ack", {31'd0, halt_ack}, 32'd1);
        run_req = 1'b1;
        cyc();
        run_req = 1'b0;
        chk("pr_resume", {31'd0, core_run_en}, 32'd1);

        // step_req in RUN is ignored.
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        $display("step_req in RUN");
        for (int i = 0; i < 3; i++) begin
            chk("ig_step_ack", {31'd0, step_ack}, 32'd0);
            chk("ig_run_en", {31'd0, core_run_en}, 32'd1);
            cyc();
        end

        // Reset during STEP_EXEC with a CSR response pending.
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        cyc();
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        chk("rs_in_step", {31'd0, core_run_en}, 32'd1);
        csr_bus.csr_req_valid = 1'b1;
        csr_bus.csr_req_write = 1'b0;
        csr_bus.csr_req_addr  = A_STATUS;
        csr_bus.csr_req_priv  = 2'd1;
        rst = 1'b1;
        cyc();
        csr_bus.csr_req_valid = 1'b0;
        rst = 1'b0;
        $display("rst during STEP_EXEC with CSR request");
        chk("rs_rsp_valid", {31'd0, csr_bus.csr_rsp_valid}, 32'd0);
        chk("rs_run_en", {31'd0, core_run_en}, 32'd1);
        chk("rs_halt_ack", {31'd0, halt_ack}, 32'd0);
        chk("rs_ready", {31'd0, csr_bus.csr_req_ready}, 32'd1);
        csr_xfer(1'b0, A_STATUS, 32'd0, 4'h0, 2'd1, rd, flt);
        chk("rs_status", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
